c16_irq_ctrl: RTL
=================

// Module: c16_irq_ctrl
// PURPOSE
//   Interrupt controller feeding the c16 core's int_trig input. Captures rising edges on
//   external sources into a pending register, applies a mask and fixed priority, and
//   raises int_trig. It then tracks the core's take/return handshake (ack on entry, done on
//   rti) so only one interrupt is in service at a time. Its registers sit on the core's
//   I/O space (addr[15] set) as four 16-bit registers.
// PARAMETERS
//   NUM_SRC   4    number of interrupt sources (1..16); index 0 is highest priority
//   TIMER_W   16   width of optional interval timer counter/reload
// PORTS
//   clk        in   1        system clock
//   reset      in   1        asynchronous, active-high reset
//   src_in     in   NUM_SRC  source lines, synchronous to clk, rising edge = event
//   cfg_wen    in   1        register write strobe (one cycle)
//   cfg_addr   in   2        register select: 0 MASK, 1 PEND, 2 RELOAD, 3 STATUS
//   cfg_wdata  in   16       write data
//   cfg_rdata  out  16       read data, combinational from cfg_addr
//   int_ack    in   1        core took interrupt (pulse, same cycle pc<=isr)
//   int_done   in   1        core executed rti (pulse)
//   int_trig   out  1        interrupt request to core, registered
//   int_id     out  4        index of granted/in-service source, registered
// BEHAVIOUR
//   Reset (async): state=IDLE, mask=0, pend=0, src_q=0, reload=0, counter=0, int_trig=0,
//     int_id=0. cfg_rdata follows register contents (0 after reset).
//   Edge detect: src_q<=src_in each clk; edge=src_in&~src_q sets pend bit at that clk edge.
//   PEND write is write-1-to-clear; set (edge or timer) beats clear in the same cycle.
//   MASK write replaces mask[NUM_SRC-1:0]; upper bits read 0. STATUS read-only:
//     {state[1:0], 10'b0, int_id}; writes ignored.
//   req = |(pend & mask); winner = lowest set index of pend&mask.
//   FSM (3 states):
//     IDLE   : req -> REQ, int_id<=winner, int_trig<=1.
//     REQ    : int_ack -> ACTIVE, int_trig<=0, clear pend[int_id] (edge same cycle on same
//              bit keeps it set). No ack and req drops (mask/W1C) -> IDLE, int_trig<=0.
//              No ack, req holds -> int_id<=winner each cycle (higher priority may preempt
//              the request before it is taken).
//     ACTIVE : int_done -> IDLE. Further edges only accumulate in pend; no nesting.
//   int_ack outside REQ and int_done outside ACTIVE are ignored.
//   Latency: src_in rises in cycle N -> pend set at edge N+1 -> int_trig high after edge
//     N+2 (mask already set). Back-to-back: done at edge M with req still true -> int_trig
//     high after edge M+1.
//   Reset mid-service: all state cleared; core must also be reset (its int_flag is its own).
// CONFIGURATION
//   C16_IRQ_TIMER_EN defined: interval timer OR'd into source 0 event. RELOAD write loads
//     reload and counter; reload=0 disables. Counter decrements every clk while reload!=0;
//     at counter==1 sets pend[0] next edge and reloads -> one event every RELOAD cycles.
//     Reads of addr 2 return reload.
//   Not defined: no timer logic; addr 2 reads 0, writes ignored; source 0 is src_in[0] only.
// STRUCTURE
//   Package c16_irq_pkg: register address constants (IRQ_MASK=0, IRQ_PEND=1,
//     IRQ_RELOAD=2, IRQ_STATUS=3), FSM state encodings (IDLE=0, REQ=1, ACTIVE=2).
//   Sub-module c16_irq_timer (TIMER_W): reload/counter, outputs one-cycle tick; instantiated
//     only under C16_IRQ_TIMER_EN. Priority encoder stays inline.
// TESTING
//   1 reset: assert reset mid-REQ -> int_trig=0, STATUS=0, PEND=0 immediately (async).
//   2 single src: MASK=0x4, pulse src_in[2] at N -> int_trig high after N+2, int_id=2;
//     ack -> int_trig=0, PEND=0x0; done -> STATUS state=IDLE.
//   3 priority: pend 0xA with MASK=0xF -> int_id=1; ack, done -> int_id=3 raised next cycle.
//   4 mask/clear: in REQ for src 3, write PEND=0x8 -> int_trig drops next cycle, state IDLE;
//     write PEND=0x1 same cycle as src_in[0] edge -> PEND bit0 stays 1.
//   5 ignore: int_ack while IDLE and int_done while REQ -> no state change.
//   6 timer (EN): RELOAD=5, MASK=0x1 -> pend[0] sets every 5 cycles; RELOAD=0 stops events;
//     without EN, RELOAD write then read -> 0.

Source files
------------

// File: rtl/c16_irq_pkg.sv
// Shared definitions for the c16 interrupt controller: register map and FSM states.
package c16_irq_pkg;

    localparam logic [1:0] IRQ_MASK   = 2'd0;
    localparam logic [1:0] IRQ_PEND   = 2'd1;
    localparam logic [1:0] IRQ_RELOAD = 2'd2;
    localparam logic [1:0] IRQ_STATUS = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } irq_state_t;

    function automatic logic [15:0] status_word(input irq_state_t st, input logic [3:0] id);
        return {st, 10'b0, id};
    endfunction

endpackage

// File: rtl/c16_irq_timer.sv
// Interval timer: emits a one-cycle tick every RELOAD cycles; RELOAD of zero disables it.
module c16_irq_timer
    import c16_irq_pkg::*;
#(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic [TIMER_W-1:0] reload,
    output logic               tick
);

    logic [TIMER_W-1:0] counter;

    assign tick = (reload != '0) && (counter == TIMER_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload  <= '0;
            counter <= '0;
        end else if (load) begin
            reload  <= load_val;
            counter <= load_val;
        end else if (reload != '0) begin
            counter <= tick ? reload : counter - TIMER_W'(1);
        end
    end

endmodule

// File: rtl/c16_irq_ctrl.sv
// c16 interrupt controller: edge capture, mask, fixed priority and ack/done handshake.
// Optional interval timer on source 0 is built when C16_IRQ_TIMER_EN is defined.
module c16_irq_ctrl
    import c16_irq_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               cfg_wen,
    input  logic [1:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    output logic [15:0]        cfg_rdata,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               int_trig,
    output logic [3:0]         int_id
);

    irq_state_t         state;
    irq_state_t         state_next;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] masked;
    logic [NUM_SRC-1:0] timer_set;
    logic [NUM_SRC-1:0] set_bits;
    logic [NUM_SRC-1:0] clr_bits;
    logic [NUM_SRC-1:0] ack_clr;
    logic [15:0]        reload_rd;
    logic [3:0]         winner;
    logic [3:0]         id_next;
    logic               trig_next;
    logic               ack_take;
    logic               req;
    logic               mask_wen;
    logic               pend_wen;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    assign mask_wen = cfg_wen && (cfg_addr == IRQ_MASK);
    assign pend_wen = cfg_wen && (cfg_addr == IRQ_PEND);

`ifdef C16_IRQ_TIMER_EN
    logic [TIMER_W-1:0] reload;
    logic               tick;

    c16_irq_timer #(
        .TIMER_W(TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (cfg_wen && (cfg_addr == IRQ_RELOAD)),
        .load_val (cfg_wdata[TIMER_W-1:0]),
        .reload   (reload),
        .tick     (tick)
    );

    assign timer_set = NUM_SRC'(tick);
    assign reload_rd = 16'(reload);
`else
    assign timer_set = '0;
    assign reload_rd = '0;
`endif

    assign src_edge = src_in & ~src_q;
    assign masked   = pend & mask;
    assign req      = |masked;

    always_comb begin
        winner = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (masked[i]) winner = 4'(i);
        end
    end

    // New events win over a W1C write or an ack clear landing on the same bit.
    assign ack_clr  = ack_take ? (NUM_SRC'(1) << int_id) : '0;
    assign clr_bits = (pend_wen ? cfg_wdata[NUM_SRC-1:0] : '0) | ack_clr;
    assign set_bits = src_edge | timer_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q <= '0;
            mask  <= '0;
            pend  <= '0;
        end else begin
            src_q <= src_in;
            pend  <= (pend & ~clr_bits) | set_bits;
            if (mask_wen) mask <= cfg_wdata[NUM_SRC-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            int_trig <= 1'b0;
            int_id   <= 4'd0;
        end else begin
            state    <= state_next;
            int_trig <= trig_next;
            int_id   <= id_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = REQ;
            REQ: begin
                if (int_ack)  state_next = ACTIVE;
                else if (!req) state_next = IDLE;
            end
            ACTIVE:  if (int_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // While requesting, the id tracks the current winner so a higher source can preempt.
    always_comb begin
        trig_next = int_trig;
        id_next   = int_id;
        ack_take  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    trig_next = 1'b1;
                    id_next   = winner;
                end
            end
            REQ: begin
                if (int_ack) begin
                    trig_next = 1'b0;
                    ack_take  = 1'b1;
                end else if (!req) begin
                    trig_next = 1'b0;
                end else begin
                    id_next = winner;
                end
            end
            ACTIVE:  trig_next = 1'b0;
            default: trig_next = 1'b0;
        endcase
    end

    always_comb begin
        cfg_rdata = 16'h0000;
        case (cfg_addr)
            IRQ_MASK:   cfg_rdata = 16'(mask);
            IRQ_PEND:   cfg_rdata = 16'(pend);
            IRQ_RELOAD: cfg_rdata = reload_rd;
            IRQ_STATUS: cfg_rdata = status_word(state, int_id);
            default:    cfg_rdata = 16'h0000;
        endcase
    end

endmodule
